// File: rtl/indication_pipe_arbiter.sv
// rtl/indication_pipe_arbiter.sv - round-robin merge of NSRC indication pipes onto one host pipe
// Optional build macro: PIPE_ARB_PRIO0_EN (source 0 strict priority, round-robin over 1..NSRC-1)
module indication_pipe_arbiter #(
  parameter int NSRC  = 4,
  parameter int WIDTH = 128
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NSRC-1:0]       in_enq__ENA,
  input  logic [NSRC*WIDTH-1:0] in_enq_v,
  output logic [NSRC-1:0]       in_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [WIDTH-1:0]      out_enq_v,
  input  logic                  out_enq__RDY,
  output logic [NSRC-1:0]       grant
);

  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

`ifdef PIPE_ARB_PRIO0_EN
  // Source 0 sits outside the rotation, so the pointer never rests on it.
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] PTR_RST = '0;
`endif

  // One-entry holding buffer per source plus the rotation pointer.
  logic [NSRC-1:0]            buf_valid_q, buf_valid_d;
  logic [NSRC-1:0][WIDTH-1:0] buf_v_q, buf_v_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;

  logic                       any_valid;
  logic [IDX_W-1:0]           winner;
  logic [IDX_W-1:0]           ptr_next;
  logic                       xfer;
  logic [NSRC-1:0]            winner_oh;

  // Pick the first valid buffer in scan order starting at the pointer.
  // The loop runs backwards so the last overwrite is the earliest candidate.
  always_comb begin : p_winner
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = |buf_valid_q;
`ifdef PIPE_ARB_PRIO0_EN
    if (!buf_valid_q[0]) begin
      for (int k = NSRC - 2; k >= 0; k--) begin
        idx = 1 + ((int'(ptr_q) - 1 + k) % (NSRC - 1));
        if (buf_valid_q[IDX_W'(idx)]) winner = IDX_W'(idx);
      end
    end
`else
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NSRC;
      if (buf_valid_q[IDX_W'(idx)]) winner = IDX_W'(idx);
    end
`endif
  end

  // Pointer value after a grant: one past the winner, wrapping inside the rotation set.
  always_comb begin : p_ptr_next
    ptr_next = ptr_q;
`ifdef PIPE_ARB_PRIO0_EN
    if (winner != '0) begin
      if (winner == IDX_W'(NSRC - 1)) ptr_next = IDX_W'(1);
      else                            ptr_next = winner + 1'b1;
    end
`else
    if (winner == IDX_W'(NSRC - 1)) ptr_next = '0;
    else                            ptr_next = winner + 1'b1;
`endif
  end

  // Host-side transfer, grant vector and per-source ready; no path from in_enq__ENA.
  always_comb begin : p_outputs
    xfer              = any_valid & out_enq__RDY;
    out_enq__ENA      = xfer;
    out_enq_v         = any_valid ? buf_v_q[winner] : '0;
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
    grant             = winner_oh & {NSRC{xfer}};
    in_enq__RDY       = ~buf_valid_q | grant;
  end

  // Next buffer state: dequeue the winner, then let any enqueue override it.
  always_comb begin : p_next_state
    buf_valid_d = buf_valid_q;
    buf_v_d     = buf_v_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      buf_valid_d[winner] = 1'b0;
      ptr_d               = ptr_next;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (in_enq__ENA[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_v_d[i]     = in_enq_v[i*WIDTH +: WIDTH];
      end
    end
  end

  // State registers; reset drops every buffered message.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_valid_q <= '0;
      buf_v_q     <= '0;
      ptr_q       <= PTR_RST;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_v_q     <= buf_v_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule
